// File: rtl/ebi_tx_sched.sv
// Credit-aware weighted round-robin scheduler for the EBI serial transmit path.
// One message in flight; bounded retries and wait time fence off failing channels.
module ebi_tx_sched #(
  parameter int CHANNEL_NUM       = 4,
  parameter int CHANNEL_NUM_WIDTH = 2,
  parameter int WEIGHT_WIDTH      = 4,
  parameter int MAX_RETRY         = 7,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                                     if_clk,
  input  logic                                     rst,
  input  logic [CHANNEL_NUM-1:0]                   req_valid,
  output logic [CHANNEL_NUM-1:0]                   req_grant,
  input  logic [CHANNEL_NUM-1:0]                   cfg_enable,
  input  logic [CHANNEL_NUM-1:0][WEIGHT_WIDTH-1:0] cfg_weight,
  input  logic [CHANNEL_NUM-1:0]                   cfg_clear_err,
  output logic                                     link_valid,
  input  logic                                     link_ready,
  output logic [CHANNEL_NUM_WIDTH-1:0]             link_ch_id,
  input  logic                                     cpl_valid,
  input  logic                                     cpl_success,
  output logic                                     err_valid,
  output logic [CHANNEL_NUM_WIDTH-1:0]             err_ch_id,
  output logic [CHANNEL_NUM-1:0]                   err_mask,
  output logic                                     busy
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  function automatic logic [CHANNEL_NUM_WIDTH-1:0] next_ch(input logic [CHANNEL_NUM_WIDTH-1:0] ch);
    if (ch == CHANNEL_NUM_WIDTH'(CHANNEL_NUM - 1)) begin
      return '0;
    end else begin
      return ch + CHANNEL_NUM_WIDTH'(1);
    end
  endfunction

  state_t                                 r_state;
  logic [CHANNEL_NUM-1:0][WEIGHT_WIDTH-1:0] r_quota;
  logic [CHANNEL_NUM_WIDTH-1:0]           r_rr_ptr;
  logic [CHANNEL_NUM_WIDTH-1:0]           r_cur_ch;
  logic [RETRY_W-1:0]                     r_retry_cnt;
  logic [TIMER_W-1:0]                     r_timer;
  logic [CHANNEL_NUM-1:0]                 r_err_mask;
  logic                                   r_link_valid;
  logic                                   r_busy;

  logic [CHANNEL_NUM-1:0]         w_cand;
  logic [CHANNEL_NUM-1:0]         w_elig;
  logic [CHANNEL_NUM_WIDTH-1:0]   w_sel_ch;
  logic                           w_sel_found;
  logic                           w_accept;
  logic [WEIGHT_WIDTH-1:0]        w_quota_dec;
  logic                           w_err_raise;
  logic [CHANNEL_NUM-1:0]         w_err_set;

  assign w_cand   = req_valid & cfg_enable & ~r_err_mask;
  assign w_accept = r_link_valid & link_ready;

  // Eligibility and wrap-around scan for the first eligible channel from rr_ptr.
  always_comb begin
    w_elig      = '0;
    w_sel_ch    = r_rr_ptr;
    w_sel_found = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      w_elig[i] = w_cand[i] & (r_quota[i] != '0);
    end
    for (int k = 0; k < CHANNEL_NUM; k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= CHANNEL_NUM) begin
        idx = idx - CHANNEL_NUM;
      end else begin
        idx = idx;
      end
      if (!w_sel_found && w_elig[idx]) begin
        w_sel_found = 1'b1;
        w_sel_ch    = CHANNEL_NUM_WIDTH'(idx);
      end else begin
        w_sel_found = w_sel_found;
      end
    end
  end

  // Quota after the grant (saturating) and the error condition while waiting.
  always_comb begin
    w_quota_dec = r_quota[r_cur_ch];
    w_err_set   = '0;
    if (r_quota[r_cur_ch] != '0) begin
      w_quota_dec = r_quota[r_cur_ch] - WEIGHT_WIDTH'(1);
    end else begin
      w_quota_dec = '0;
    end
    w_err_raise = (r_state == S_WAIT) &&
                  ((cpl_valid && !cpl_success && (r_retry_cnt == RETRY_LAST)) ||
                   (!cpl_valid && (r_timer == TIMER_LAST)));
    if (w_err_raise) begin
      w_err_set[r_cur_ch] = 1'b1;
    end else begin
      w_err_set = '0;
    end
  end

  // Handshake-coincident pulses; suppressed while reset is asserted.
  always_comb begin
    req_grant = '0;
    err_valid = 1'b0;
    err_ch_id = '0;
    if (!rst && w_accept) begin
      req_grant[r_cur_ch] = 1'b1;
    end else begin
      req_grant = '0;
    end
    if (!rst && w_err_raise) begin
      err_valid = 1'b1;
      err_ch_id = r_cur_ch;
    end else begin
      err_valid = 1'b0;
      err_ch_id = '0;
    end
  end

  assign link_valid = r_link_valid;
  assign link_ch_id = r_cur_ch;
  assign err_mask   = r_err_mask;
  assign busy       = r_busy;

  // Scheduler FSM with its counters, quotas and sticky error bits.
  always_ff @(posedge if_clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_quota      <= '0;
      r_rr_ptr     <= '0;
      r_cur_ch     <= '0;
      r_retry_cnt  <= '0;
      r_timer      <= '0;
      r_err_mask   <= '0;
      r_link_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Set wins over a coincident clear on the same channel.
      r_err_mask <= (r_err_mask & ~cfg_clear_err) | w_err_set;
      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_cur_ch     <= w_sel_ch;
            r_state      <= S_ISSUE;
            r_link_valid <= 1'b1;
            r_busy       <= 1'b1;
          end else if (|w_cand) begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
              r_quota[i] <= (cfg_weight[i] == '0) ? WEIGHT_WIDTH'(1) : cfg_weight[i];
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_quota[r_cur_ch] <= w_quota_dec;
            r_rr_ptr          <= (w_quota_dec != '0) ? r_cur_ch : next_ch(r_cur_ch);
            r_state           <= S_WAIT;
            r_link_valid      <= 1'b0;
            r_retry_cnt       <= '0;
            r_timer           <= '0;
          end else begin
            r_state <= S_ISSUE;
          end
        end
        S_WAIT: begin
          if (w_err_raise) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_rr_ptr    <= next_ch(r_cur_ch);
            r_retry_cnt <= '0;
            r_timer     <= '0;
          end else if (cpl_valid && cpl_success) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_retry_cnt <= '0;
            r_timer     <= '0;
          end else if (cpl_valid) begin
            r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
            r_timer     <= '0;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_link_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ebi_tx_sched.sv
// Bench for ebi_tx_sched: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_ebi_tx_sched;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int WW = 4;
  localparam int MR = 7;
  localparam int TO = 16;

  logic if_clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_grant, cfg_enable = '0, cfg_clear_err = '0, err_mask;
  logic [N-1:0][WW-1:0] cfg_weight = '0;
  logic link_valid, link_ready = 1'b0, cpl_valid = 1'b0, cpl_success = 1'b0, err_valid, busy;
  logic [CW-1:0] link_ch_id, err_ch_id;

  always #5 if_clk = ~if_clk;

  ebi_tx_sched #(.CHANNEL_NUM(N), .CHANNEL_NUM_WIDTH(CW), .WEIGHT_WIDTH(WW),
                 .MAX_RETRY(MR), .TIMEOUT_CYCLES(TO)) u_dut (
    .if_clk(if_clk), .rst(rst), .req_valid(req_valid), .req_grant(req_grant),
    .cfg_enable(cfg_enable), .cfg_weight(cfg_weight), .cfg_clear_err(cfg_clear_err),
    .link_valid(link_valid), .link_ready(link_ready), .link_ch_id(link_ch_id),
    .cpl_valid(cpl_valid), .cpl_success(cpl_success), .err_valid(err_valid),
    .err_ch_id(err_ch_id), .err_mask(err_mask), .busy(busy));

  // Stimulus for the next cycle, applied on the falling edge.
  bit s_rst;
  bit [N-1:0] s_req, s_en, s_clr;
  int s_wt [N];
  bit s_ready, s_cv, s_cs;

  // Reference model: one message in flight, issued or not yet issued.
  int m_quota [N];
  int m_ptr, m_ch, m_fails, m_wait;
  bit m_inflight, m_issued;
  bit [N-1:0] m_err;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_quota[i] = 0;
    m_ptr = 0; m_ch = 0; m_fails = 0; m_wait = 0;
    m_inflight = 0; m_issued = 0; m_err = '0;
  endtask

  task automatic model_step();
    bit [N-1:0] elig, cand;
    bit raise;
    int sel;
    if (s_rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      cand[i] = s_req[i] && s_en[i] && !m_err[i];
      elig[i] = cand[i] && (m_quota[i] > 0);
    end
    raise = 0;
    m_err = m_err & ~s_clr;
    if (!m_inflight) begin
      if (elig != '0) begin
        sel = -1;
        for (int k = 0; k < N; k++)
          if (sel < 0 && elig[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
        m_ch = sel; m_inflight = 1; m_issued = 0;
      end else if (cand != '0) begin
        for (int i = 0; i < N; i++) m_quota[i] = (s_wt[i] == 0) ? 1 : s_wt[i];
      end
    end else if (!m_issued) begin
      if (s_ready) begin
        m_issued = 1;
        m_quota[m_ch]--;
        m_ptr = (m_quota[m_ch] != 0) ? m_ch : (m_ch + 1) % N;
        m_fails = 0; m_wait = 0;
      end
    end else begin
      if (s_cv && s_cs) begin
        m_inflight = 0; m_fails = 0; m_wait = 0;
      end else if (s_cv) begin
        if (m_fails + 1 >= MR) raise = 1;
        else begin m_fails++; m_wait = 0; end
      end else if (m_wait == TO - 1) raise = 1;
      else m_wait++;
    end
    if (raise) begin
      m_err[m_ch] = 1'b1;
      m_inflight = 0;
      m_ptr = (m_ch + 1) % N;
      m_fails = 0; m_wait = 0;
    end
  endtask

  task automatic cycle();
    bit lv, ee;
    bit [N-1:0] eg;
    int ech;
    @(negedge if_clk);
    rst = s_rst; req_valid = s_req; cfg_enable = s_en; cfg_clear_err = s_clr;
    for (int i = 0; i < N; i++) cfg_weight[i] = WW'(s_wt[i]);
    link_ready = s_ready; cpl_valid = s_cv; cpl_success = s_cs;
    #1;
    lv = m_inflight && !m_issued;
    eg = '0;
    if (!s_rst && lv && s_ready) eg[m_ch] = 1'b1;
    ee = !s_rst && m_inflight && m_issued &&
         ((s_cv && !s_cs && (m_fails + 1 >= MR)) || (!s_cv && (m_wait == TO - 1)));
    ech = ee ? m_ch : 0;
    chk("link_valid", 32'(link_valid), 32'(lv));
    chk("link_ch_id", 32'(link_ch_id), 32'(m_ch));
    chk("busy", 32'(busy), 32'(m_inflight));
    chk("req_grant", 32'(req_grant), 32'(eg));
    chk("err_valid", 32'(err_valid), 32'(ee));
    chk("err_ch_id", 32'(err_ch_id), 32'(ech));
    chk("err_mask", 32'(err_mask), 32'(m_err));
    model_step();
  endtask

  task automatic set_defaults();
    s_rst = 0; s_req = '0; s_en = '1; s_clr = '0;
    for (int i = 0; i < N; i++) s_wt[i] = 1;
    s_ready = 1; s_cv = 0; s_cs = 1;
  endtask

  task automatic do_reset();
    set_defaults();
    s_rst = 1;
    cycle();
    cycle();
    s_rst = 0;
  endtask

  task automatic run_to_wait();
    s_cv = 0;
    for (int k = 0; k < 20; k++) begin
      if (m_inflight && m_issued) break;
      cycle();
    end
  endtask

  int first_lv, ng, ne, errk, errch, stable;
  int gc [6];
  int t1_exp [3] = '{2, 5, 9};
  int t2_exp [6] = '{0, 0, 1, 0, 0, 1};
  int p_cv, p_cs, p_rdy, p_req;

  initial begin
    model_reset();
    set_defaults();

    // Single channel, weight 2, instant success.
    do_reset();
    s_wt[0] = 2; s_req = 4'b0001; s_cv = 1; s_cs = 1;
    first_lv = -1; ng = 0;
    for (int i = 0; i < 6; i++) gc[i] = -1;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (link_valid === 1'b1 && first_lv < 0) first_lv = c;
      if (req_grant[0] === 1'b1) begin
        if (ng < 3) gc[ng] = c;
        ng++;
      end
    end
    chk("t1_first_link_valid", 32'(first_lv), 32'd2);
    for (int i = 0; i < 3; i++) chk("t1_grant_cycle", 32'(gc[i]), 32'(t1_exp[i]));

    // Weights 2 and 1 on channels 0 and 1.
    do_reset();
    s_wt[0] = 2; s_wt[1] = 1; s_req = 4'b0011; s_cv = 1; s_cs = 1;
    ng = 0;
    for (int i = 0; i < 6; i++) gc[i] = -1;
    for (int c = 0; c < 24; c++) begin
      cycle();
      for (int ch = 0; ch < N; ch++)
        if (req_grant[ch] === 1'b1) begin
          if (ng < 6) gc[ng] = ch;
          ng++;
        end
    end
    for (int i = 0; i < 6; i++) chk("t2_grant_order", 32'(gc[i]), 32'(t2_exp[i]));

    // Backpressure: link_ready low for five issue cycles.
    do_reset();
    s_req = 4'b0100; s_ready = 0;
    cycle(); cycle();
    stable = 0; ng = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (link_valid === 1'b1 && link_ch_id === 2'd2) stable++;
      if (req_grant !== 4'b0000) ng++;
    end
    s_ready = 1;
    cycle();
    if (req_grant !== 4'b0000) ng++;
    s_req = '0; s_cv = 1;
    cycle(); cycle();
    s_cv = 0;
    chk("t3_stable_cycles", 32'(stable), 32'd5);
    chk("t3_grant_pulses", 32'(ng), 32'd1);

    // Retry limit: six fails then success, then seven fails.
    do_reset();
    s_req = 4'b0001;
    run_to_wait();
    ne = 0;
    s_cv = 1; s_cs = 0;
    for (int k = 0; k < 6; k++) begin cycle(); if (err_valid === 1'b1) ne++; end
    s_cs = 1;
    cycle();
    if (err_valid === 1'b1) ne++;
    chk("t4_no_err_after_6_fails", 32'(ne), 32'd0);
    run_to_wait();
    errk = -1; errch = -1;
    s_cv = 1; s_cs = 0;
    for (int k = 0; k < 7; k++) begin
      cycle();
      if (err_valid === 1'b1 && errk < 0) begin errk = k; errch = int'(err_ch_id); end
    end
    s_cv = 0; s_cs = 1;
    chk("t4_err_on_7th_fail", 32'(errk), 32'd6);
    chk("t4_err_ch", 32'(errch), 32'd0);
    cycle();
    chk("t4_err_mask_set", 32'(err_mask), 32'h1);
    ng = 0;
    for (int k = 0; k < 6; k++) begin cycle(); if (req_grant !== 4'b0000) ng++; end
    chk("t4_channel_fenced", 32'(ng), 32'd0);
    s_clr = 4'b0001;
    cycle();
    s_clr = '0;
    ng = 0;
    for (int k = 0; k < 6; k++) begin cycle(); if (req_grant[0] === 1'b1) ng++; end
    chk("t4_grant_after_clear", 32'(ng), 32'd1);

    // Timeout, and a completion landing exactly in the timeout cycle.
    do_reset();
    s_req = 4'b1000;
    run_to_wait();
    errk = -1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (err_valid === 1'b1 && errk < 0) errk = k;
    end
    chk("t5_timeout_wait_cycle", 32'(errk), 32'd16);
    chk("t5_timeout_mask", 32'(err_mask), 32'h8);
    do_reset();
    s_req = 4'b1000;
    run_to_wait();
    ne = 0;
    for (int k = 1; k <= 15; k++) begin cycle(); if (err_valid === 1'b1) ne++; end
    s_cv = 1; s_cs = 1;
    cycle();
    if (err_valid === 1'b1) ne++;
    s_cv = 0;
    cycle();
    chk("t5_cpl_in_timeout_cycle", 32'(ne), 32'd0);
    chk("t5_no_mask", 32'(err_mask), 32'h0);

    // Coincident clear and error set, then reset in the middle of a wait.
    do_reset();
    s_req = 4'b0010;
    run_to_wait();
    for (int k = 0; k < 15; k++) cycle();
    s_clr = 4'b0010;
    cycle();
    ne = (err_valid === 1'b1) ? 1 : 0;
    s_clr = '0;
    cycle();
    chk("t6_err_pulse", 32'(ne), 32'd1);
    chk("t6_set_wins", 32'(err_mask), 32'h2);
    s_req = 4'b0001;
    run_to_wait();
    for (int k = 0; k < 3; k++) cycle();
    s_rst = 1; s_cv = 1; s_cs = 0;
    cycle();
    s_rst = 0; s_cv = 0; s_req = '0;
    cycle();
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_link_valid", 32'(link_valid), 32'd0);
    chk("t6_rst_mask", 32'(err_mask), 32'h0);
    chk("t6_rst_ch", 32'(link_ch_id), 32'd0);

    // Randomized traffic with phase-varying probabilities.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        p_cv  = int'($urandom_range(2, 60));
        p_cs  = int'($urandom_range(0, 100));
        p_rdy = int'($urandom_range(20, 100));
        p_req = int'($urandom_range(30, 100));
        for (int i = 0; i < N; i++) s_wt[i] = int'($urandom_range(0, 4));
      end
      for (int i = 0; i < N; i++) begin
        s_req[i] = (int'($urandom_range(1, 100)) <= p_req);
        s_en[i]  = (int'($urandom_range(1, 100)) <= 90);
        s_clr[i] = (int'($urandom_range(1, 100)) <= 2);
      end
      s_ready = (int'($urandom_range(1, 100)) <= p_rdy);
      s_cv    = (int'($urandom_range(1, 100)) <= p_cv);
      s_cs    = (int'($urandom_range(1, 100)) <= p_cs);
      s_rst   = ($urandom_range(1, 1000) == 1);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
